// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter and select sequencer for the shared 4:1 data mux.
//   Four requesters contend for the mux output. One owner is granted at a
//   time, and the mux select pair is driven from registered state.
//
//   Optional feature: define MUX_ARB_TIMEOUT_EN to force a handover once an
//   owner has held the grant for MAX_HOLD cycles while another request is
//   pending. Without the macro, an owner keeps the grant until it drops req.
//
// Parameters
//   MAX_HOLD  consecutive grant cycles per owner with timeout on (2..15)
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   req[3:0]  request vector, bit i selects mux input i (a,b,c,d)
//   grant     registered one-hot grant, zero when idle
//   s1, s0    registered mux select, index of the current / last owner
//   valid     registered, high while the mux output is owned
module mux4_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic       s1,
   output logic       s0,
   output logic       valid
);

`ifdef MUX_ARB_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t     state, state_d;
   logic [1:0] owner, owner_d;
   logic [1:0] last, last_d;
   logic [3:0] hold_cnt, hold_d;
   logic [1:0] winner;
   logic       others;
   logic       expire;

   // First requester found scanning last+1 .. last+4 (mod 4).
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] from);
      logic [1:0] idx;
      logic       found;
      pick  = from;
      found = 1'b0;
      for (int unsigned k = 1; k <= 4; k++) begin
         idx = from + 2'(k);
         if (!found && r[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   endfunction

   always_comb begin
      state_d = state;
      owner_d = owner;
      last_d  = last;
      hold_d  = hold_cnt;

      // While granted, last == owner, so the scan never re-picks the owner
      // as long as some other request is pending.
      winner  = pick(req, last);
      others  = |(req & ~(4'b0001 << owner));
      expire  = TIMEOUT_EN && (hold_cnt == HOLD_LAST) && others;

      case (state)
         IDLE: begin
            if (|req) begin
               state_d = GRANT;
               owner_d = winner;
               last_d  = winner;
               hold_d  = '0;
            end
         end
         GRANT: begin
            if (req[owner] && !expire) begin
               hold_d = (hold_cnt == 4'hF) ? 4'hF : hold_cnt + 4'd1;
            end else if (others) begin
               owner_d = winner;
               last_d  = winner;
               hold_d  = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         owner    <= 2'd0;
         last     <= 2'd3;
         hold_cnt <= '0;
      end else begin
         state    <= state_d;
         owner    <= owner_d;
         last     <= last_d;
         hold_cnt <= hold_d;
      end
   end

   // Outputs are registered from the next-state values so they reflect the
   // new state in the same cycle the state register does. In IDLE the select
   // keeps the previous owner index so the mux output stays stable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant <= '0;
         s1    <= 1'b0;
         s0    <= 1'b0;
         valid <= 1'b0;
      end else begin
         grant <= (state_d == GRANT) ? (4'b0001 << owner_d) : '0;
         s1    <= owner_d[1];
         s0    <= owner_d[0];
         valid <= (state_d == GRANT);
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter
//   Self-checking bench for mux4_rr_arbiter: a directed vector table,
//   hand-written multi-cycle sequences (long hold, timeout rotation,
//   asynchronous reset) and a randomized run against a reference model.
//   Honours MUX_ARB_TIMEOUT_EN the same way as the design.
module tb_mux4_rr_arbiter;

   localparam int unsigned MAX_HOLD = 8;
`ifdef MUX_ARB_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] req;
   logic [3:0] grant;
   logic       s1;
   logic       s0;
   logic       valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .grant   (grant),
      .s1      (s1),
      .s0      (s0),
      .valid   (valid)
   );

   // ---------------- reference model ----------------
   bit m_busy;
   int m_owner;
   int m_last;
   int m_hold;

   task automatic model_reset();
      m_busy  = 1'b0;
      m_owner = 0;
      m_last  = 3;
      m_hold  = 0;
   endtask

   function automatic int m_pick(input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         if (r[(m_last + k) % 4]) return (m_last + k) % 4;
      end
      return m_last;
   endfunction

   task automatic model_step(input logic [3:0] r);
      bit others;
      bit expired;
      int w;
      others = 1'b0;
      for (int j = 0; j < 4; j++) begin
         if (j != m_owner && r[j]) others = 1'b1;
      end
      w = m_pick(r);
      if (!m_busy) begin
         if (r != 4'b0000) begin
            m_busy  = 1'b1;
            m_owner = w;
            m_last  = w;
            m_hold  = 0;
         end
      end else begin
         expired = TIMEOUT_EN && (m_hold == MAX_HOLD - 1) && others;
         if (r[m_owner] && !expired) begin
            m_hold = (m_hold >= 15) ? 15 : m_hold + 1;
         end else if (others) begin
            m_owner = w;
            m_last  = w;
            m_hold  = 0;
         end else begin
            m_busy = 1'b0;
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic [3:0] g, input logic v,
                          input logic [1:0] sel);
      chk({name, ".grant"}, 32'(grant), 32'(g));
      chk({name, ".valid"}, 32'(valid), 32'(v));
      chk({name, ".sel"},   32'({s1, s0}), 32'(sel));
   endtask

   // Drive req, clock one edge, advance the model, sample 1 time unit later.
   task automatic step(input logic [3:0] r);
      req = r;
      @(posedge clk);
      model_step(r);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [3:0] req;
      logic [3:0] grant;
      logic       valid;
      logic [1:0] sel;
   } vec_t;

   vec_t vecs[14];

   initial begin
      int         wait_cnt[4];
      logic [3:0] r;
      logic [3:0] prev_grant;
      int         exp_owner;

      // From reset: rotation 0->1->2->3->0, idle, direct handover, rotation.
      vecs[0]  = '{4'b1111, 4'b0001, 1'b1, 2'd0};
      vecs[1]  = '{4'b1110, 4'b0010, 1'b1, 2'd1};
      vecs[2]  = '{4'b1100, 4'b0100, 1'b1, 2'd2};
      vecs[3]  = '{4'b1001, 4'b1000, 1'b1, 2'd3};
      vecs[4]  = '{4'b0001, 4'b0001, 1'b1, 2'd0};
      vecs[5]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
      vecs[6]  = '{4'b0100, 4'b0100, 1'b1, 2'd2};
      vecs[7]  = '{4'b0100, 4'b0100, 1'b1, 2'd2};
      vecs[8]  = '{4'b1001, 4'b1000, 1'b1, 2'd3};
      vecs[9]  = '{4'b0000, 4'b0000, 1'b0, 2'd3};
      vecs[10] = '{4'b0011, 4'b0001, 1'b1, 2'd0};
      vecs[11] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
      vecs[12] = '{4'b1111, 4'b0010, 1'b1, 2'd1};
      vecs[13] = '{4'b0000, 4'b0000, 1'b0, 2'd1};

      // Reset with all requests raised.
      reset_n = 1'b0;
      req     = 4'b1111;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_out("reset", 4'b0000, 1'b0, 2'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         step(vecs[i].req);
         chk_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].valid, vecs[i].sel);
      end

      // Requester 1 alone for 20 cycles, then release: select stays 01.
      for (int i = 0; i < 20; i++) begin
         step(4'b0010);
         chk_out($sformatf("hold1_c%0d", i), 4'b0010, 1'b1, 2'd1);
      end
      step(4'b0000);
      chk_out("hold1_release", 4'b0000, 1'b0, 2'd1);

      // Requesters 0 and 1 held together: rotation every MAX_HOLD cycles
      // with the timeout, requester 0 keeps it forever without.
      for (int t = 0; t < 40; t++) begin
         step(4'b0011);
         exp_owner = TIMEOUT_EN ? ((t / MAX_HOLD) % 2) : 0;
         chk_out($sformatf("timeout_c%0d", t), 4'(1 << exp_owner), 1'b1, 2'(exp_owner));
      end
      step(4'b0000);
      chk_out("timeout_release", 4'b0000, 1'b0, 2'(exp_owner));

      // Asynchronous reset between clock edges while owner 2 holds.
      step(4'b0100);
      chk_out("pre_areset", 4'b0100, 1'b1, 2'd2);
      #3;
      reset_n = 1'b0;
      #1;
      chk_out("areset", 4'b0000, 1'b0, 2'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      step(4'b0100);
      chk_out("post_areset", 4'b0100, 1'b1, 2'd2);
      step(4'b0000);
      chk_out("post_areset_idle", 4'b0000, 1'b0, 2'd2);

      // Randomized traffic against the model, plus structural and fairness checks.
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         r = req;
         for (int i = 0; i < 4; i++) begin
            if (r[i]) begin
               if (grant[i]) begin
                  if ($urandom_range(3) == 0) r[i] = 1'b0;
               end else if ($urandom_range(15) == 0) begin
                  r[i] = 1'b0;
               end
            end else if ($urandom_range(3) == 0) begin
               r[i] = 1'b1;
            end
         end
         prev_grant = grant;
         step(r);
         chk("rand.grant", 32'(grant), 32'(m_busy ? (1 << m_owner) : 0));
         chk("rand.valid", 32'(valid), 32'(m_busy));
         chk("rand.sel", 32'({s1, s0}), 32'(m_owner));
         chk("rand.onehot0", 32'($onehot0(grant)), 32'd1);
         if (grant != 4'b0000)
            chk("rand.sel_vs_grant", 32'(grant), 32'(4'b0001 << {s1, s0}));
         for (int i = 0; i < 4; i++) begin
            if (!r[i] || grant[i])
               wait_cnt[i] = 0;
            else if (grant != 4'b0000 && grant != prev_grant)
               wait_cnt[i]++;
            if (wait_cnt[i] > 3)
               chk($sformatf("rand.wait_req%0d", i), 32'(wait_cnt[i]), 32'd3);
            else
               checks++;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and select sequencer for the 4:1 data mux (`one_bit_4_1_mux` and its multi-bit versions). Four requesters contend for the shared mux output. The block grants one requester at a time and drives the mux select pair (s1, s0) from a registered state machine. Fairness is rotating priority, and an optional hold timeout stops any one requester from monopolising the mux.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per owner when the timeout feature is compiled in. Legal range is 2–15.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset. Assertion takes effect immediately. Deassertion is synchronous to `clk` by system convention.
- `req` input 4: request vector. `req[i]` maps to mux input i (0=a, 1=b, 2=c, 3=d).
- `grant` output 4: one-hot grant, or all-zero when idle. Registered.
- `s1` output 1: mux select MSB. Equals bit 1 of the current owner index. Registered.
- `s0` output 1: mux select LSB. Equals bit 0 of the current owner index. Registered.
- `valid` output 1: high while a grant is active, meaning the mux output is owned. Registered.

## Operation
- States: IDLE and GRANT.
- Internal registers:
  - `owner[1:0]`: current owner index.
  - `last[1:0]`: index of the most recent owner, i.e. the priority pointer.
  - `hold_cnt`: 4-bit counter.
- Selection function: scan indices last+1, last+2, last+3, last+4 (mod 4) in that order. The first index with `req` high wins.
- IDLE:
  - If `req` is 4'b0000, remain in IDLE.
  - Otherwise, the winner becomes `owner` and `last`. Go to GRANT and clear `hold_cnt`.
- GRANT:
  - If `req[owner]` is high and the timeout has not expired, keep the owner and increment `hold_cnt`. The counter saturates at 15.
  - If `req[owner]` is low and another request is pending, hand over directly to the new winner in the next cycle, with no idle bubble. Update `last` and clear `hold_cnt`.
  - If `req[owner]` is low and no other request is pending, go to IDLE.
- Outputs are a pure function of the registered state:
  - GRANT: `grant` = 1<<owner, {s1,s0} = owner, `valid` = 1.
  - IDLE: `grant` = 0, `valid` = 0, and {s1,s0} hold the last owner's index so the mux stays stable.
- `grant` is never more than one-hot. The select pair always matches the index of the set grant bit.
- Reset values:
  - State IDLE, `grant` 4'b0000, `valid` 0, s1=0, s0=0.
  - `owner` 2'd0, `last` 2'd3, so requester 0 has top priority after reset.
  - `hold_cnt` 0.
- Reset in mid-grant drops `grant` and `valid` immediately, asynchronously, and restores all reset values.

## Timing
- Request to grant latency is 1 cycle. If `req` is sampled high on edge N in IDLE, `grant`, `valid` and the selects update after edge N.
- Release to handover is 1 cycle. If `req[owner]` is sampled low on edge N, the next owner is visible after edge N.
- The mux data path is combinational. Mux output is valid in the same cycle as `valid`.
- Simultaneous requests resolve purely by the rotating order. A requester that has just been granted has the lowest priority in the next arbitration.
- A requester that drops and re-raises `req` while still owner in the same cycle is not distinguishable. Requesters must deassert for at least one sampled edge to release.

## Configuration
- `MUX_ARB_TIMEOUT_EN` defined:
  - In GRANT, when `hold_cnt` equals MAX_HOLD-1 and another request is pending, the grant is forcibly passed to the next winner on that edge, even if `req[owner]` is still high.
  - If no other request is pending, the owner keeps the grant and `hold_cnt` saturates.
- `MUX_ARB_TIMEOUT_EN` undefined:
  - No forced handover. The owner keeps the grant until it drops `req`.
  - `hold_cnt` is still implemented but does not affect transitions.

## Test plan
- Reset with `req`=4'b1111, then release reset: one cycle later `grant`=4'b0001, {s1,s0}=00, `valid`=1. Repeated one-cycle releases then give the grant order 0→1→2→3→0.
- Owner 2 holding, `req` changes from 4'b0100 to 4'b1001 on one edge: next cycle `grant`=4'b1000, {s1,s0}=11, with no idle cycle.
- `req[1]` only, held 20 cycles, then dropped: `grant` stays 4'b0010 for 20 cycles. Next cycle `grant`=0, `valid`=0 and {s1,s0} stays 01.
- With `MUX_ARB_TIMEOUT_EN` and MAX_HOLD=8, `req`=4'b0011 held continuously: grant alternates between 0 and 1 every 8 cycles. Without the macro, 0 keeps the grant indefinitely.
- Assert `reset_n` low asynchronously mid-grant, between clock edges: `grant`=0, `valid`=0 and {s1,s0}=00 immediately. After release with `req`=4'b0100, grant goes to 2 one cycle later.
- Random `req` for 10,000 cycles: `grant` is always one-hot or zero, and {s1,s0} always matches the granted index. No requester that holds `req` waits more than 3 owner tenures.
